// File: rtl/pc_sn_pipe_if.sv
// Handshake bundle for pc_sn_pipe: valid/ready input carrying the bits to count,
// valid/ready output carrying their population count.
interface pc_sn_pipe_if #(
    parameter int N     = 15,
    parameter int OUT_W = $clog2(N + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/pc_sn_pipe.sv
// pc_sn_pipe: pipelined population count built from a bitonic sorting network.
// Define PC_SN_ACCUM_EN to add the saturating accumulator (parameter ACC_W, ports acc_clear/acc_sum).
module pc_sn_pipe #(
    parameter int N      = 15,
    parameter int STAGES = 2
`ifdef PC_SN_ACCUM_EN
  , parameter int ACC_W  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef PC_SN_ACCUM_EN
    input  logic             acc_clear,
    output logic [ACC_W-1:0] acc_sum,
`endif
    pc_sn_pipe_if.slave      bus
);
    localparam int OUT_W = $clog2(N + 1);
    localparam int LOGP  = $clog2(N);
    localparam int P     = 1 << LOGP;
    localparam int L     = LOGP * (LOGP + 1) / 2;

    // Applies bitonic layers lo..hi-1; ones collect at the low indices (thermometer code).
    function automatic logic [P-1:0] sort_layers(input logic [P-1:0] v, input int lo, input int hi);
        logic [P-1:0] d;
        logic [P-1:0] q;
        int idx;
        int j;
        int k;
        int m;
        d   = v;
        idx = 0;
        for (int s = 1; s <= LOGP; s++) begin
            for (int t = s - 1; t >= 0; t--) begin
                if (idx >= lo && idx < hi) begin
                    q = d;
                    j = 1 << t;
                    k = 1 << s;
                    for (int i = 0; i < P; i++) begin
                        if ((i & j) == 0) begin
                            m = i | j;
                            if ((i & k) == 0) begin
                                q[i] = d[i] | d[m];
                                q[m] = d[i] & d[m];
                            end else begin
                                q[i] = d[i] & d[m];
                                q[m] = d[i] | d[m];
                            end
                        end
                    end
                    d = q;
                end
                idx++;
            end
        end
        return d;
    endfunction

    // Edge of the thermometer (t[i] & ~t[i+1]) marks count i+1.
    function automatic logic [OUT_W-1:0] therm_to_bin(input logic [P-1:0] t);
        logic [P:0]       te;
        logic [OUT_W-1:0] c;
        te = {1'b0, t};
        c  = '0;
        for (int i = 0; i < P; i++) begin
            if (te[i] && !te[i+1]) c = c | OUT_W'(i + 1);
        end
        return c;
    endfunction

    logic [STAGES:1]   valid_q;
    logic [STAGES-1:0] vld_in;
    logic [STAGES+1:1] rdy;
    logic [P-1:0]      stage_in  [1:STAGES];
    logic [P-1:0]      stage_out [1:STAGES];
    logic [OUT_W-1:0]  count_q;

    // NOTE: every variable assigned in always_comb gets a value on all paths, or a latch is inferred.
    always_comb begin
        rdy            = '0;
        rdy[STAGES+1]  = bus.out_ready;
        for (int s = STAGES; s >= 1; s--) rdy[s] = !valid_q[s] || rdy[s+1];
        vld_in         = '0;
        vld_in[0]      = bus.in_valid;
        for (int s = 1; s < STAGES; s++) vld_in[s] = valid_q[s];
    end

    assign stage_in[1] = P'(bus.in_data);

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        localparam int LO = (L * (s - 1)) / STAGES;
        localparam int HI = (L * s) / STAGES;

        assign stage_out[s] = sort_layers(stage_in[s], LO, HI);

        if (s < STAGES) begin : g_reg
            logic [P-1:0] pipe_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                  pipe_q <= '0;
                else if (rdy[s] && vld_in[s-1]) pipe_q <= stage_out[s];
            end
            assign stage_in[s+1] = pipe_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                if (rdy[s]) valid_q[s] <= vld_in[s-1];
            end
            if (rdy[STAGES] && vld_in[STAGES-1]) count_q <= therm_to_bin(stage_out[STAGES]);
        end
    end

    assign bus.in_ready  = rdy[1];
    assign bus.out_valid = valid_q[STAGES];
    assign bus.out_count = count_q;

`ifdef PC_SN_ACCUM_EN
    localparam int SUM_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

    logic [ACC_W-1:0] acc_q;
    logic [SUM_W-1:0] acc_next;

    // A clear coinciding with a transfer restarts the sum from the transferred count.
    always_comb begin
        acc_next = (acc_clear ? '0 : SUM_W'(acc_q)) + SUM_W'(count_q);
        if (acc_next > ACC_MAX) acc_next = ACC_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            acc_q <= '0;
        else if (valid_q[STAGES] && bus.out_ready) acc_q <= ACC_W'(acc_next);
        else if (acc_clear)                    acc_q <= '0;
    end

    assign acc_sum = acc_q;
`endif
endmodule

// File: doc/pc_sn_pipe.md
PC_SN_PIPE -- requirements
Module: pc_sn_pipe

Interface
REQ-001 Parameter N, default 15: number of input bits to count; legal range 3..64.
REQ-002 Parameter STAGES, default 2: pipeline register stages; legal range 1..4.
REQ-003 Parameter ACC_W, default 16: accumulator width; used only when PC_SN_ACCUM_EN is defined.
REQ-004 Derived constant OUT_W SHALL equal $clog2(N+1).
REQ-005 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1 bit: in_data is valid.
REQ-008 Port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-009 Port in_data, input, N bits: bits to be counted.
REQ-010 Port out_valid, output, 1 bit: out_count is valid.
REQ-011 Port out_ready, input, 1 bit: downstream accepts out_count.
REQ-012 Port out_count, output, OUT_W bits: number of ones in the accepted in_data.

Function
REQ-013 The count SHALL be formed by a sorting network: in_data padded with zeros to the next power of two, then sorted to a thermometer code; adjacent-bit XOR gives a one-hot position; the one-hot is encoded to binary. An adder tree SHALL NOT be used.
REQ-014 Comparator layers SHALL be split across STAGES register boundaries as evenly as possible; the encoder SHALL sit in the last stage.
REQ-015 A transfer SHALL occur on an interface when valid and ready are both 1 at a rising clk edge.
REQ-016 Latency SHALL be exactly STAGES cycles from the input transfer to out_valid=1, when there is no stall.
REQ-017 Throughput SHALL be one transfer per cycle while out_ready=1.
REQ-018 Each stage SHALL hold a valid bit; the stage is ready when its valid bit is 0 or the next stage is ready. in_ready SHALL equal the stage-1 ready term.
REQ-019 A stage holding valid data that is not ready SHALL keep its data and valid bit unchanged; no data SHALL be dropped or duplicated.
REQ-020 out_count and out_valid SHALL be driven directly from the last-stage registers.
REQ-021 in_data=0 SHALL give out_count=0; all ones SHALL give out_count=N.
REQ-022 Pipeline bubbles (in_valid=0) SHALL propagate as out_valid=0 and SHALL NOT corrupt neighbouring stages.

Reset
REQ-023 While rst_n=0, all valid bits SHALL be 0, out_valid=0, out_count=0, and in_ready=1.
REQ-024 Asserting rst_n mid-stream SHALL discard all in-flight data immediately, without waiting for a clk edge.
REQ-025 After rst_n is released, the first input transfer SHALL be possible on the first rising clk edge.

Configuration
REQ-026 Macro PC_SN_ACCUM_EN SHALL control the accumulator feature.
REQ-027 When PC_SN_ACCUM_EN is defined, the block SHALL add an input acc_clear (1 bit) and an output acc_sum (ACC_W bits).
REQ-028 On each output transfer, acc_sum SHALL add out_count, saturating at 2^ACC_W-1.
REQ-029 acc_clear=1 SHALL set acc_sum to 0 on the next edge. If clear and an output transfer coincide, acc_sum SHALL load out_count.
REQ-030 acc_sum SHALL reset to 0.
REQ-031 When PC_SN_ACCUM_EN is undefined, acc_clear and acc_sum SHALL be absent and no accumulator logic SHALL exist.

Verification
REQ-032 Scenario: N=15, STAGES=2, out_ready=1; inputs 0x0000, 0x7FFF, 0x5555 on consecutive cycles -> out_count 0, 15, 8 on cycles 2, 3, 4, with out_valid=1 on each.
REQ-033 Scenario: stream 0x0001..0x0010, with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 within 2 cycles, all 16 counts delivered in order, none lost.
REQ-034 Scenario: exhaustive 2^N inputs for N=7, STAGES=1 and for N=9, STAGES=3, with random out_ready -> every out_count equals the popcount.
REQ-035 Scenario: rst_n pulsed low with 2 items in flight -> out_valid=0 asynchronously, and after release the next input 0x00FF yields 8.
REQ-036 Scenario (PC_SN_ACCUM_EN, ACC_W=4): counts 15, 15 -> acc_sum=15 (saturated); acc_clear together with a count-7 transfer -> acc_sum=7.
